// File: rtl/pz_pkg.sv
// Shared definitions for the processor-Z program loader.
// Contents: loader state encoding, word/address geometry, and a few
// opcode constants that benches use to build instruction streams.
package pz_pkg;

    localparam int PZ_ADDR_W         = 9;
    localparam int PZ_WORD_W         = 32;
    localparam int PZ_BYTES_PER_WORD = 4;

    // Opcode constants for building test programs.
    localparam logic [7:0] PZ_IRMOV = 8'h10;
    localparam logic [3:0] PZ_ALU   = 4'h2;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_WRITE = 2'd1,
        ST_RUN   = 2'd2,
        ST_ERROR = 2'd3
    } loader_state_e;

endpackage

// File: rtl/program_loader_if.sv
// Bus bundle between a byte source / processor and the program loader.
// Ports (loader view, modport slave):
//   in   in_valid, in_data[7:0], in_last, restart
//   out  in_ready, addr[ADDR_W-1:0], wr, wdata[DATA_W-1:0], working,
//        word_count[ADDR_W:0], err
// modport master is the mirror image, used by the source/processor side.
interface program_loader_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_last;
    logic              restart;
    logic              in_ready;
    logic [ADDR_W-1:0] addr;
    logic              wr;
    logic [DATA_W-1:0] wdata;
    logic              working;
    logic [ADDR_W:0]   word_count;
    logic              err;

    modport slave (
        input  in_valid, in_data, in_last, restart,
        output in_ready, addr, wr, wdata, working, word_count, err
    );

    modport master (
        output in_valid, in_data, in_last, restart,
        input  in_ready, addr, wr, wdata, working, word_count, err
    );
endinterface

// File: rtl/byte_packer.sv
// Big-endian byte-to-word packer: a 4-byte shift register and a 2-bit
// byte counter.
// Ports:
//   clock_i, reset_i  clock, async active-high reset
//   clear_i           synchronous clear of word and counter (dominates shift)
//   shift_i           shift byte_i into the low byte of the word
//   byte_i[7:0]       incoming byte
//   word_o            assembled word (first byte ends up in the top byte)
//   full_o            the next shifted byte completes the word
module byte_packer
    import pz_pkg::*;
#(
    parameter int DATA_W = PZ_WORD_W
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              clear_i,
    input  logic              shift_i,
    input  logic [7:0]        byte_i,
    output logic [DATA_W-1:0] word_o,
    output logic              full_o
);

    logic [DATA_W-1:0] word_q;
    logic [1:0]        count_q;

    // Shift register and byte counter; the counter wraps 3 -> 0 on the 4th byte.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            word_q  <= {DATA_W{1'b0}};
            count_q <= 2'd0;
        end else if (clear_i) begin
            word_q  <= {DATA_W{1'b0}};
            count_q <= 2'd0;
        end else if (shift_i) begin
            word_q  <= {word_q[DATA_W-9:0], byte_i};
            count_q <= count_q + 2'd1;
        end else begin
            word_q  <= word_q;
            count_q <= count_q;
        end
    end

    assign word_o = word_q;
    assign full_o = (count_q == 2'd3);

endmodule

// File: rtl/program_loader.sv
// Boot-time writer for processor Z's instruction RAM. Packs a byte stream
// into 32-bit big-endian words, writes them to consecutive addresses from 0
// and raises working once the word carrying in_last has been stored.
// Ports:
//   clock  single clock, rising edge
//   reset  async active-high, returns to LOAD
//   bus    program_loader_if.slave (byte handshake in, RAM write + status out)
module program_loader
    import pz_pkg::*;
#(
    parameter int ADDR_W = PZ_ADDR_W,
    parameter int DATA_W = PZ_WORD_W
) (
    input  logic             clock,
    input  logic             reset,
    program_loader_if.slave  bus
);

    localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    loader_state_e     state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   word_count_q;
    logic              last_q;
    logic              wr_q, wr_d;
    logic              working_q, working_d;
    logic              err_q, err_d;
    logic              ready_s;
    logic              accept_s;
    logic              full_s;
    logic [DATA_W-1:0] word_s;

    // restart blocks acceptance in its own cycle so no byte is lost or merged.
    assign ready_s  = (state_q == ST_LOAD) && !bus.restart;
    assign accept_s = bus.in_valid && ready_s;

    byte_packer #(.DATA_W(DATA_W)) u_packer (
        .clock_i (clock),
        .reset_i (reset),
        .clear_i (bus.restart),
        .shift_i (accept_s),
        .byte_i  (bus.in_data),
        .word_o  (word_s),
        .full_o  (full_s)
    );

    // State register plus registered status strobes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_LOAD;
            wr_q      <= 1'b0;
            working_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_q      <= wr_d;
            working_q <= working_d;
            err_q     <= err_d;
        end
    end

    // Next-state logic; restart overrides every state.
    always_comb begin
        state_d = state_q;
        if (bus.restart) begin
            state_d = ST_LOAD;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (accept_s && full_s) begin
                        state_d = ST_WRITE;
                    end else if (accept_s && bus.in_last) begin
                        // in_last before the 4th byte: framing error
                        state_d = ST_ERROR;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
                ST_WRITE: begin
                    if (last_q) begin
                        state_d = ST_RUN;
                    end else if (addr_q == ADDR_MAX) begin
                        state_d = ST_ERROR;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
                ST_RUN:   state_d = ST_RUN;
                ST_ERROR: state_d = ST_ERROR;
                default:  state_d = ST_LOAD;
            endcase
        end
    end

    // Output decode from the next state, so the strobes are registered.
    always_comb begin
        wr_d      = 1'b0;
        working_d = 1'b0;
        err_d     = 1'b0;
        case (state_d)
            ST_WRITE: wr_d      = 1'b1;
            ST_RUN:   working_d = 1'b1;
            ST_ERROR: err_d     = 1'b1;
            ST_LOAD:  wr_d      = 1'b0;
            default:  wr_d      = 1'b0;
        endcase
    end

    // Address, word counter and the in_last flag of the word being written.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_q       <= {ADDR_W{1'b0}};
            word_count_q <= {(ADDR_W+1){1'b0}};
            last_q       <= 1'b0;
        end else if (bus.restart) begin
            addr_q       <= {ADDR_W{1'b0}};
            word_count_q <= {(ADDR_W+1){1'b0}};
            last_q       <= 1'b0;
        end else begin
            if (accept_s && full_s) begin
                last_q <= bus.in_last;
            end else begin
                last_q <= last_q;
            end
            if (state_q == ST_WRITE) begin
                word_count_q <= word_count_q + CNT_ONE;
                // Overflow check precedes the increment: the top address never wraps.
                if (!last_q && (addr_q != ADDR_MAX)) begin
                    addr_q <= addr_q + ADDR_ONE;
                end else begin
                    addr_q <= addr_q;
                end
            end else begin
                word_count_q <= word_count_q;
                addr_q       <= addr_q;
            end
        end
    end

    assign bus.in_ready   = ready_s;
    assign bus.addr       = addr_q;
    assign bus.wr         = wr_q;
    assign bus.wdata      = word_s;
    assign bus.working    = working_q;
    assign bus.word_count = word_count_q;
    assign bus.err        = err_q;

endmodule
